// File: rtl/ext_buffered.sv
// Integer width converter (zero-extend / sign-extend / truncate) with a two-slot elastic output buffer.
// Latency: 1 cycle from acceptance to outs when empty; sustains 1 token/cycle while outs_ready=1.
// Backpressure: a skid register absorbs one token after outs_ready drops; ins_ready falls once the skid is full.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-low reset
//   ins        : input data (INPUT_TYPE bits)
//   ins_valid  : input token valid
//   ins_ready  : block can accept a token (low during reset and while the skid holds data)
//   outs       : converted data from the main register (OUTPUT_TYPE bits)
//   outs_valid : main register holds a token
//   outs_ready : consumer accepts the token on outs
module ext_buffered #(
  parameter int INPUT_TYPE  = 32,
  parameter int OUTPUT_TYPE = 64,
  parameter int EXT_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_TYPE-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic [OUTPUT_TYPE-1:0] outs,
  output logic                   outs_valid,
  input  logic                   outs_ready
);

  logic [OUTPUT_TYPE-1:0] conv_dat;

  // Width conversion is purely combinational on ins; only converted values are stored.
  generate
    if (INPUT_TYPE < 1 || OUTPUT_TYPE < 1 || EXT_MODE < 0 || EXT_MODE > 2 ||
        (EXT_MODE < 2 && OUTPUT_TYPE < INPUT_TYPE) ||
        (EXT_MODE == 2 && OUTPUT_TYPE > INPUT_TYPE)) begin : g_illegal
      $error("ext_buffered: illegal INPUT_TYPE/OUTPUT_TYPE/EXT_MODE combination");
      assign conv_dat = '0;
    end else if (OUTPUT_TYPE == INPUT_TYPE) begin : g_pass
      assign conv_dat = ins;
    end else if (EXT_MODE == 2) begin : g_trunc
      logic unused_hi;
      assign unused_hi = ^ins[INPUT_TYPE-1:OUTPUT_TYPE];
      assign conv_dat  = ins[OUTPUT_TYPE-1:0];
    end else if (EXT_MODE == 1) begin : g_sext
      assign conv_dat = {{(OUTPUT_TYPE-INPUT_TYPE){ins[INPUT_TYPE-1]}}, ins};
    end else begin : g_zext
      assign conv_dat = {{(OUTPUT_TYPE-INPUT_TYPE){1'b0}}, ins};
    end
  endgenerate

  logic                   main_valid_q, main_valid_d;
  logic                   skid_valid_q, skid_valid_d;
  logic [OUTPUT_TYPE-1:0] main_dat_q,   main_dat_d;
  logic [OUTPUT_TYPE-1:0] skid_dat_q,   skid_dat_d;
  logic                   ins_fire;
  logic                   outs_fire;

  // ins_ready depends only on rst and a register, never on outs_ready.
  assign ins_ready  = rst & ~skid_valid_q;
  assign outs_valid = main_valid_q;
  assign outs       = main_dat_q;

  assign ins_fire  = ins_valid & ins_ready;
  assign outs_fire = main_valid_q & outs_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_dat_d   = main_dat_q;
    skid_dat_d   = skid_dat_q;
    if (skid_valid_q) begin
      // FULL: input is blocked; draining main promotes the skid token.
      if (outs_fire) begin
        main_dat_d   = skid_dat_q;
        skid_valid_d = 1'b0;
      end
    end else if (main_valid_q) begin
      if (ins_fire && outs_fire) begin
        main_dat_d = conv_dat;
      end else if (outs_fire) begin
        main_valid_d = 1'b0;
      end else if (ins_fire) begin
        // Consumer stalled: park the newcomer in the skid so main stays stable.
        skid_valid_d = 1'b1;
        skid_dat_d   = conv_dat;
      end
    end else if (ins_fire) begin
      main_valid_d = 1'b1;
      main_dat_d   = conv_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_dat_q   <= '0;
      skid_dat_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_dat_q   <= main_dat_d;
      skid_dat_q   <= skid_dat_d;
    end
  end

endmodule

// File: tb/tb_ext_buffered.sv
module tb_ext_buffered;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Sign-extend 8->16 instance: main subject of the streaming/backpressure/random tests.
  logic [7:0]  s_ins = '0;
  logic        s_ins_valid = 1'b0;
  logic        s_ins_ready;
  logic [15:0] s_outs;
  logic        s_outs_valid;
  logic        s_outs_ready = 1'b0;

  // Zero-extend 8->16 instance.
  logic [7:0]  z_ins = '0;
  logic        z_ins_valid = 1'b0;
  logic        z_ins_ready;
  logic [15:0] z_outs;
  logic        z_outs_valid;
  logic        z_outs_ready = 1'b1;

  // Truncate 16->8 instance.
  logic [15:0] t_ins = '0;
  logic        t_ins_valid = 1'b0;
  logic        t_ins_ready;
  logic [7:0]  t_outs;
  logic        t_outs_valid;
  logic        t_outs_ready = 1'b1;

  ext_buffered #(.INPUT_TYPE(8), .OUTPUT_TYPE(16), .EXT_MODE(1)) u_sext (
    .clk(clk), .rst(rst), .ins(s_ins), .ins_valid(s_ins_valid), .ins_ready(s_ins_ready),
    .outs(s_outs), .outs_valid(s_outs_valid), .outs_ready(s_outs_ready));

  ext_buffered #(.INPUT_TYPE(8), .OUTPUT_TYPE(16), .EXT_MODE(0)) u_zext (
    .clk(clk), .rst(rst), .ins(z_ins), .ins_valid(z_ins_valid), .ins_ready(z_ins_ready),
    .outs(z_outs), .outs_valid(z_outs_valid), .outs_ready(z_outs_ready));

  ext_buffered #(.INPUT_TYPE(16), .OUTPUT_TYPE(8), .EXT_MODE(2)) u_trunc (
    .clk(clk), .rst(rst), .ins(t_ins), .ins_valid(t_ins_valid), .ins_ready(t_ins_ready),
    .outs(t_outs), .outs_valid(t_outs_valid), .outs_ready(t_outs_ready));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of the sign-extend instance: a depth-2 FIFO of converted values.
  logic [15:0] q[$];

  function automatic logic [15:0] sext8(input logic [7:0] x);
    int v;
    v = int'(x);
    if (v >= 128) v = v - 256;
    return 16'(v);
  endfunction

  // Advance one clock: update the model with what the coming edge will transfer,
  // then move to the next falling edge where outputs are sampled.
  task automatic tick();
    bit inf, outf;
    if (!rst) begin
      q.delete();
    end else begin
      inf  = s_ins_valid && (q.size() < 2);
      outf = s_outs_ready && (q.size() > 0);
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(sext8(s_ins));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_ins_valid = 1'b1;
    s_ins = 8'h5A;
    tick();
    tick();
    n_cmp++; if (s_ins_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ins_ready got=%b exp=0", s_ins_ready); end
    n_cmp++; if (s_outs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_outs_valid got=%b exp=0", s_outs_valid); end
    n_cmp++; if (s_outs !== 16'h0000) begin n_fail++; $display("FAIL reset_outs got=%h exp=0000", s_outs); end
    s_ins_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (s_ins_ready !== 1'b1) begin n_fail++; $display("FAIL release_ins_ready got=%b exp=1", s_ins_ready); end
    tick();
    n_cmp++; if (s_outs_valid !== 1'b0) begin n_fail++; $display("FAIL release_outs_valid got=%b exp=0", s_outs_valid); end
  endtask

  task automatic test_sign_extend();
    logic [7:0]  vin [3];
    logic [15:0] vexp[3];
    vin  = '{8'h80, 8'h7F, 8'hFF};
    vexp = '{16'hFF80, 16'h007F, 16'hFFFF};
    s_outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_ins = vin[i];
      s_ins_valid = 1'b1;
      n_cmp++; if (s_ins_ready !== 1'b1) begin n_fail++; $display("FAIL sext_ins_ready[%0d] got=%b exp=1", i, s_ins_ready); end
      tick();
      n_cmp++; if (s_outs_valid !== 1'b1) begin n_fail++; $display("FAIL sext_valid[%0d] got=%b exp=1", i, s_outs_valid); end
      n_cmp++; if (s_outs !== vexp[i]) begin n_fail++; $display("FAIL sext_outs[%0d] got=%h exp=%h", i, s_outs, vexp[i]); end
    end
    s_ins_valid = 1'b0;
    tick();
    n_cmp++; if (s_outs_valid !== 1'b0) begin n_fail++; $display("FAIL sext_drain got=%b exp=0", s_outs_valid); end
  endtask

  task automatic test_zero_trunc();
    logic [15:0] v;
    logic [15:0] zexp;
    logic [7:0]  texp;
    for (int i = 0; i < 9; i++) begin
      v = (i == 0) ? 16'h1234 : 16'($urandom);
      z_ins = (i == 0) ? 8'h80 : v[7:0];
      t_ins = v;
      z_ins_valid = 1'b1;
      t_ins_valid = 1'b1;
      zexp = 16'(int'(z_ins));
      texp = 8'(int'(t_ins) % 256);
      tick();
      n_cmp++; if (z_outs_valid !== 1'b1 || z_outs !== zexp) begin n_fail++; $display("FAIL zext[%0d] got=%b/%h exp=1/%h", i, z_outs_valid, z_outs, zexp); end
      n_cmp++; if (t_outs_valid !== 1'b1 || t_outs !== texp) begin n_fail++; $display("FAIL trunc[%0d] got=%b/%h exp=1/%h", i, t_outs_valid, t_outs, texp); end
    end
    z_ins_valid = 1'b0;
    t_ins_valid = 1'b0;
    tick();
    n_cmp++; if (z_outs_valid !== 1'b0 || t_outs_valid !== 1'b0) begin n_fail++; $display("FAIL zt_drain got=%b%b exp=00", z_outs_valid, t_outs_valid); end
  endtask

  task automatic test_back_to_back();
    s_outs_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_ins = 8'(i);
      s_ins_valid = 1'b1;
      n_cmp++; if (s_ins_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, s_ins_ready); end
      if (i > 0) begin
        n_cmp++; if (s_outs_valid !== 1'b1 || s_outs !== 16'(i - 1)) begin n_fail++; $display("FAIL stream_out[%0d] got=%b/%h exp=1/%h", i, s_outs_valid, s_outs, 16'(i - 1)); end
      end
      tick();
    end
    s_ins_valid = 1'b0;
    n_cmp++; if (s_outs_valid !== 1'b1 || s_outs !== 16'd15) begin n_fail++; $display("FAIL stream_last got=%b/%h exp=1/000f", s_outs_valid, s_outs); end
    tick();
    n_cmp++; if (s_outs_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got=%b exp=0", s_outs_valid); end
  endtask

  task automatic test_backpressure();
    s_outs_ready = 1'b0;
    s_ins = 8'h11; s_ins_valid = 1'b1;
    n_cmp++; if (s_ins_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_a got=%b exp=1", s_ins_ready); end
    tick();
    s_ins = 8'h92;
    n_cmp++; if (s_ins_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_b got=%b exp=1", s_ins_ready); end
    tick();
    s_ins = 8'h33;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (s_ins_ready !== 1'b0) begin n_fail++; $display("FAIL bp_block_c[%0d] got=%b exp=0", i, s_ins_ready); end
      n_cmp++; if (s_outs_valid !== 1'b1 || s_outs !== 16'h0011) begin n_fail++; $display("FAIL bp_stable[%0d] got=%b/%h exp=1/0011", i, s_outs_valid, s_outs); end
      tick();
    end
    s_outs_ready = 1'b1;
    tick();
    n_cmp++; if (s_outs !== 16'hFF92) begin n_fail++; $display("FAIL bp_out_b got=%h exp=ff92", s_outs); end
    n_cmp++; if (s_ins_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen got=%b exp=1", s_ins_ready); end
    tick();
    s_ins_valid = 1'b0;
    n_cmp++; if (s_outs_valid !== 1'b1 || s_outs !== 16'h0033) begin n_fail++; $display("FAIL bp_out_c got=%b/%h exp=1/0033", s_outs_valid, s_outs); end
    tick();
    n_cmp++; if (s_outs_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", s_outs_valid); end
  endtask

  task automatic test_random();
    int consumed;
    int cycles;
    consumed = 0;
    cycles = 0;
    while (consumed < 1000 && cycles < 20000) begin
      n_cmp++; if (s_ins_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cycles, s_ins_ready, q.size() < 2); end
      n_cmp++; if (s_outs_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cycles, s_outs_valid, q.size() > 0); end
      if (q.size() > 0) begin
        n_cmp++; if (s_outs !== q[0]) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cycles, s_outs, q[0]); end
      end
      s_ins_valid  = ($urandom_range(99) < 70);
      s_outs_ready = ($urandom_range(99) < 60);
      s_ins        = 8'($urandom);
      if (s_outs_ready && q.size() > 0) consumed++;
      tick();
      cycles++;
    end
    n_cmp++; if (consumed < 1000) begin n_fail++; $display("FAIL rnd_timeout consumed=%0d exp=1000", consumed); end
    s_ins_valid = 1'b0;
    s_outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (q.size() > 0) begin
        n_cmp++; if (s_outs_valid !== 1'b1 || s_outs !== q[0]) begin n_fail++; $display("FAIL rnd_flush[%0d] got=%b/%h exp=1/%h", i, s_outs_valid, s_outs, q[0]); end
      end
      tick();
    end
    n_cmp++; if (s_outs_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_empty got=%b exp=0", s_outs_valid); end
  endtask

  task automatic test_reset_full();
    s_outs_ready = 1'b0;
    s_ins_valid = 1'b1;
    s_ins = 8'hA1; tick();
    s_ins = 8'hA2; tick();
    n_cmp++; if (s_ins_ready !== 1'b0) begin n_fail++; $display("FAIL rf_full got=%b exp=0", s_ins_ready); end
    rst = 1'b0;
    s_ins = 8'hA3;
    tick();
    n_cmp++; if (s_outs_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid got=%b exp=0", s_outs_valid); end
    n_cmp++; if (s_outs !== 16'h0000) begin n_fail++; $display("FAIL rf_outs got=%h exp=0000", s_outs); end
    n_cmp++; if (s_ins_ready !== 1'b0) begin n_fail++; $display("FAIL rf_ready_in_reset got=%b exp=0", s_ins_ready); end
    rst = 1'b1;
    s_ins_valid = 1'b0;
    s_outs_ready = 1'b1;
    #1;
    n_cmp++; if (s_ins_ready !== 1'b1) begin n_fail++; $display("FAIL rf_ready_after got=%b exp=1", s_ins_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (s_outs_valid !== 1'b0) begin n_fail++; $display("FAIL rf_stale[%0d] got=%b exp=0", i, s_outs_valid); end
    end
    s_ins = 8'h05;
    s_ins_valid = 1'b1;
    tick();
    s_ins_valid = 1'b0;
    n_cmp++; if (s_outs_valid !== 1'b1 || s_outs !== 16'h0005) begin n_fail++; $display("FAIL rf_fresh got=%b/%h exp=1/0005", s_outs_valid, s_outs); end
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sign_extend();
    test_zero_trunc();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
